// File: rtl/amiq_muxn_arb.sv
// -----------------------------------------------------------------------------
// amiq_muxn_arb
//   N-channel valid/ready multiplexer with a single-entry registered output.
//   MODE 0 forwards the channel named by sel; MODE 1 grants round-robin among
//   the channels presenting valid data, starting after the last winner.
//   Input accepts back-to-back with output drains, so full throughput is
//   sustained while out_ready stays high.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sel        channel select (MODE 0 only)
//   in_data    packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept (combinational)
//   out_data   registered data of the accepted channel
//   out_valid  registered output valid
//   out_ready  downstream accept
//   out_src    registered index of the channel that supplied out_data
//   xfer_cnt   wrapping count of completed output transfers
// -----------------------------------------------------------------------------
module amiq_muxn_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW-1:0]        sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_src,
  output logic [15:0]          xfer_cnt
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SW-1:0]    out_src_q,   out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      xfer_cnt_q,  xfer_cnt_d;
  logic [SW-1:0]    ptr_q,       ptr_d;

  logic             load_en;
  logic [SW-1:0]    grant;
  logic             grant_vld;
  logic [SW-1:0]    scan_idx;
  logic [WIDTH-1:0] grant_data;
  logic             in_xfer;

  // The output slot can take new data when empty or when it drains this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Channel selection. In round-robin mode the scan runs from the far end
  // back towards ptr so the last write wins, i.e. the first valid channel at
  // or after ptr (mod N) is granted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        grant     = sel;
        grant_vld = 1'b1;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        scan_idx = SW'((int'(ptr_q) + i) % N);
        if (in_valid[scan_idx]) begin
          grant     = scan_idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // One-hot accept and data mux keyed by the grant index.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_vld && (grant == SW'(k))) begin
        in_ready[k] = load_en && !rst;
        grant_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_xfer = |(in_valid & in_ready);

  // Next state: a drain empties the slot unless a load refills it in the
  // same cycle, giving back-to-back transfers without a bubble.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    ptr_d       = ptr_q;
    if (out_valid_q && out_ready) begin
      xfer_cnt_d  = xfer_cnt_q + 16'd1;
      out_valid_d = 1'b0;
    end
    if (in_xfer) begin
      out_data_d  = grant_data;
      out_src_d   = grant;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = SW'((int'(grant) + 1) % N);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_amiq_muxn_arb.sv
// -----------------------------------------------------------------------------
// tb_amiq_muxn_arb
//   Drives one external-select instance (u_sel, MODE 0) and one round-robin
//   instance (u_rr, MODE 1), both N=4, WIDTH=8, and compares them cycle by
//   cycle against a transaction-level reference model of the slot, the
//   transfer counter and the round-robin pointer.
// -----------------------------------------------------------------------------
module tb_amiq_muxn_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  sel0, sel1;
  logic [31:0] id0, id1;
  logic [3:0]  iv0, iv1, ir0, ir1;
  logic        ord0, ord1;
  logic [7:0]  od0, od1;
  logic        ov0, ov1;
  logic [1:0]  os0, os1;
  logic [15:0] oc0, oc1;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = MODE 0 instance, 1 = MODE 1 instance.
  logic        rv [2];
  logic [7:0]  rd [2];
  int          rs [2];
  logic [15:0] rc [2];
  int          rptr;

  always #5 clk = ~clk;

  amiq_muxn_arb #(.WIDTH(8), .N(4), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .sel(sel0), .in_data(id0), .in_valid(iv0),
    .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(ord0),
    .out_src(os0), .xfer_cnt(oc0)
  );

  amiq_muxn_arb #(.WIDTH(8), .N(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .sel(sel1), .in_data(id1), .in_valid(iv1),
    .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(ord1),
    .out_src(os1), .xfer_cnt(oc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      rv[m] = 1'b0; rd[m] = '0; rs[m] = 0; rc[m] = '0;
    end
    rptr = 0;
  endtask

  // Which channel the spec says may transfer this cycle.
  function automatic logic [3:0] exp_ready(int m, logic [1:0] s, logic [3:0] v, logic ordy);
    int ch;
    if (rv[m] && !ordy) return 4'b0;
    if (m == 0) return 4'b0001 << s;
    for (int k = 0; k < 4; k++) begin
      ch = (rptr + k) % 4;
      if (v[ch]) return 4'b0001 << ch;
    end
    return 4'b0;
  endfunction

  task automatic model_update(int m, logic [3:0] v, logic [31:0] d, logic [3:0] er, logic ordy);
    logic out_x, in_x;
    out_x = rv[m] && ordy;
    in_x  = |(v & er);
    if (out_x) rc[m] = rc[m] + 16'd1;
    if (in_x) begin
      for (int g = 0; g < 4; g++) begin
        if (er[g]) begin
          rd[m] = d[g*8 +: 8];
          rs[m] = g;
          if (m == 1) rptr = (g + 1) % 4;
        end
      end
      rv[m] = 1'b1;
    end else if (out_x) begin
      rv[m] = 1'b0;
    end
  endtask

  task automatic check_outs();
    check("valid0", 32'(ov0), 32'(rv[0]));
    check("data0",  32'(od0), 32'(rd[0]));
    check("src0",   32'(os0), 32'(rs[0]));
    check("cnt0",   32'(oc0), 32'(rc[0]));
    check("valid1", 32'(ov1), 32'(rv[1]));
    check("data1",  32'(od1), 32'(rd[1]));
    check("src1",   32'(os1), 32'(rs[1]));
    check("cnt1",   32'(oc1), 32'(rc[1]));
  endtask

  // One clock cycle: drive on the falling edge, check accepts, advance the
  // model, then check registered outputs just after the rising edge.
  task automatic step(input logic [1:0] s0, input logic [3:0] v0, input logic [31:0] d0,
                      input logic r0, input logic [3:0] v1, input logic [31:0] d1,
                      input logic r1);
    logic [3:0] e0, e1;
    @(negedge clk);
    sel0 = s0; iv0 = v0; id0 = d0; ord0 = r0;
    iv1 = v1; id1 = d1; ord1 = r1;
    #1;
    e0 = exp_ready(0, s0, v0, r0);
    e1 = exp_ready(1, 2'd0, v1, r1);
    check("ready0", 32'(ir0), 32'(e0));
    check("ready1", 32'(ir1), 32'(e1));
    model_update(0, v0, d0, e0, r0);
    model_update(1, v1, d1, e1, r1);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic rand_step(input logic r0, input logic r1);
    step(2'($urandom_range(0, 3)), 4'($urandom), $urandom, r0,
         4'($urandom), $urandom, r1);
  endtask

  initial begin
    logic [7:0]  hold_d0, hold_d1;
    logic [1:0]  hold_s0, hold_s1;
    logic [15:0] hold_c0, hold_c1;

    sel0 = '0; sel1 = '0; id0 = '0; id1 = '0;
    iv0 = '0; iv1 = '0; ord0 = 1'b0; ord1 = 1'b0;
    model_reset();

    // Reset state, and no accepts while reset is high even with valid data.
    repeat (2) @(posedge clk);
    @(negedge clk);
    iv0 = 4'hF; iv1 = 4'hF; ord0 = 1'b1; ord1 = 1'b1;
    #1;
    check("rst_ready0", 32'(ir0), 32'h0);
    check("rst_ready1", 32'(ir1), 32'h0);
    check_outs();
    iv0 = '0; iv1 = '0;
    rst = 1'b0;

    // External select of channel 2 carrying 0xA5.
    step(2'd2, 4'b0100, 32'h11A5_2233, 1'b1, 4'b0000, 32'h0, 1'b1);
    check("sel_data", 32'(od0), 32'hA5);
    check("sel_src",  32'(os0), 32'd2);

    // Round-robin with all channels valid and no backpressure.
    for (int i = 0; i < 6; i++) begin
      step(2'd0, 4'b0000, 32'h0, 1'b1, 4'hF, $urandom, 1'b1);
      check("rr_seq", 32'(os1), 32'(i % 4));
      check("rr_valid", 32'(ov1), 32'd1);
    end

    // Grant channel 2 (pointer moves to 3), then 0011 twice: grant 0 then 1.
    step(2'd0, 4'b0000, 32'h0, 1'b1, 4'b0100, $urandom, 1'b1);
    step(2'd0, 4'b0000, 32'h0, 1'b1, 4'b0011, $urandom, 1'b1);
    check("rr_wrap_g0", 32'(os1), 32'd0);
    step(2'd0, 4'b0000, 32'h0, 1'b1, 4'b0011, $urandom, 1'b1);
    check("rr_next_g1", 32'(os1), 32'd1);

    // Backpressure for five cycles with changing inputs, then release.
    step(2'd3, 4'hF, $urandom, 1'b1, 4'hF, $urandom, 1'b1);
    hold_d0 = od0; hold_s0 = os0; hold_c0 = oc0;
    hold_d1 = od1; hold_s1 = os1; hold_c1 = oc1;
    repeat (5) rand_step(1'b0, 1'b0);
    check("bp_data0", 32'(od0), 32'(hold_d0));
    check("bp_src0",  32'(os0), 32'(hold_s0));
    check("bp_data1", 32'(od1), 32'(hold_d1));
    check("bp_src1",  32'(os1), 32'(hold_s1));
    step(2'd0, 4'b0000, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b1);
    check("bp_cnt0", 32'(oc0), 32'(hold_c0 + 16'd1));
    check("bp_cnt1", 32'(oc1), 32'(hold_c1 + 16'd1));
    check("bp_empty0", 32'(ov0), 32'd0);

    // Randomised traffic with occasional backpressure.
    for (int i = 0; i < 400; i++)
      rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    // Reset pulse between edges while both slots hold data.
    step(2'd1, 4'hF, $urandom, 1'b0, 4'hF, $urandom, 1'b0);
    @(negedge clk);
    iv0 = '0; iv1 = '0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_valid0", 32'(ov0), 32'd0);
    check("midrst_valid1", 32'(ov1), 32'd0);
    check("midrst_cnt0",   32'(oc0), 32'd0);
    check("midrst_cnt1",   32'(oc1), 32'd0);
    check("midrst_ready1", 32'(ir1), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++)
      rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    // Run both counters to 65535, then one more transfer wraps them to 0.
    for (int n = 0; n < 70000 && !(rc[0] == 16'hFFFF && rc[1] == 16'hFFFF); n++)
      step(2'd1, 4'hF, $urandom, rc[0] != 16'hFFFF, 4'hF, $urandom, rc[1] != 16'hFFFF);
    check("cnt_max0", 32'(oc0), 32'hFFFF);
    check("cnt_max1", 32'(oc1), 32'hFFFF);
    step(2'd1, 4'hF, $urandom, 1'b1, 4'hF, $urandom, 1'b1);
    check("cnt_wrap0", 32'(oc0), 32'd0);
    check("cnt_wrap1", 32'(oc1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
